// File: rtl/add_slice.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : add_slice
// Purpose  : Combinational CW-bit adder with carry-in and carry-out. One
//            instance sits in every pipeline stage of pipe_add and adds one
//            operand chunk.
// Ports    : a_i  [CW-1:0]  operand A chunk
//            b_i  [CW-1:0]  effective operand B chunk (already inverted on
//                           subtract)
//            c_i            carry into the chunk LSB
//            s_o  [CW-1:0]  chunk sum
//            c_o            carry out of the chunk MSB
// Revision : 1.0 - initial release
// ============================================================================
module add_slice #(
   parameter int CW = 8
) (
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   input  logic          c_i,
   output logic [CW-1:0] s_o,
   output logic          c_o
);

   // Widen by one bit so the carry out falls naturally into the top bit.
   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};

endmodule
`default_nettype wire

// File: rtl/pipe_add.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_add
// Purpose  : Pipelined WIDTH-bit add/subtract unit. Operands are split into
//            STAGES chunks of CW = WIDTH/STAGES bits; the carry ripples one
//            chunk per clock so the critical path is one CW-bit adder no
//            matter how wide the datapath grows. Valid/ready on both sides,
//            one operation per cycle, latency STAGES edges (the accept edge
//            counts as the first).
// Ports    : clock               rising-edge clock
//            reset               asynchronous active-high reset
//            in_valid / in_ready input handshake for A, B, Sub, Cin
//            A, B    [WIDTH-1:0] operands
//            Sub                 0: A+B+Cin   1: A-B-Cin (Cin is borrow-in)
//            Cin                 carry-in / borrow-in
//            out_valid/out_ready output handshake for C, Cout, Overflow
//            C       [WIDTH-1:0] result modulo 2^WIDTH
//            Cout                carry out of MSB (subtract: 1 = no borrow)
//            Overflow            two's-complement signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module pipe_add #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sub,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             Cout,
   output logic             Overflow
);

   localparam int CW  = WIDTH / STAGES;
   localparam int MSB = WIDTH - 1;

   if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_add: WIDTH must be a positive multiple of STAGES");
   end

   // ------------------------------------------------------------------------
   // Handshake: the whole pipe advances as one unit. It may move whenever the
   // output slot is empty or is being drained this cycle.
   // ------------------------------------------------------------------------
   logic             w_adv;
   logic             w_accept;
   logic [WIDTH-1:0] w_beff;
   logic             w_c0;

   assign w_adv    = ~out_valid | out_ready;
   assign in_ready = w_adv & ~reset;
   assign w_accept = in_valid & in_ready;

   // Subtract is A + ~B + (1 - borrow_in).
   assign w_beff = Sub ? ~B : B;
   assign w_c0   = Sub ^ Cin;

   // ------------------------------------------------------------------------
   // Stage k adds chunk k. It keeps the result chunks 0..k, its carry, the
   // operand chunks that are still to be added, both operand sign bits and a
   // valid flag. Data registers only load when a real operation arrives, so
   // bubbles never disturb them and undriven inputs never reach them.
   // ------------------------------------------------------------------------
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO  = k * CW;
      // Operand bits above this stage's chunk, still waiting to be added.
      localparam int REM = WIDTH - LO - CW;

      logic [CW-1:0]    w_a;
      logic [CW-1:0]    w_b;
      logic             w_cin;
      logic             w_vin;
      logic             w_sa;
      logic             w_sb;
      logic [CW-1:0]    w_sum;
      logic             w_cout;
      logic [LO+CW-1:0] res_d;

      logic [LO+CW-1:0] res_q;
      logic             carry_q;
      logic             sa_q;
      logic             sb_q;
      logic             valid_q;

      add_slice #(
         .CW (CW)
      ) u_slice (
         .a_i (w_a),
         .b_i (w_b),
         .c_i (w_cin),
         .s_o (w_sum),
         .c_o (w_cout)
      );

      if (k == 0) begin : g_head
         assign w_a   = A[CW-1:0];
         assign w_b   = w_beff[CW-1:0];
         assign w_cin = w_c0;
         assign w_vin = w_accept;
         assign w_sa  = A[MSB];
         assign w_sb  = w_beff[MSB];
         assign res_d = w_sum;
      end else begin : g_body
         // Lowest remaining chunk of the previous stage is this stage's chunk.
         assign w_a   = g_stage[k-1].g_rem.a_rem_q[CW-1:0];
         assign w_b   = g_stage[k-1].g_rem.b_rem_q[CW-1:0];
         assign w_cin = g_stage[k-1].carry_q;
         assign w_vin = g_stage[k-1].valid_q;
         assign w_sa  = g_stage[k-1].sa_q;
         assign w_sb  = g_stage[k-1].sb_q;
         assign res_d = {w_sum, g_stage[k-1].res_q};
      end

      if (REM > 0) begin : g_rem
         logic [REM-1:0] a_rem_d;
         logic [REM-1:0] b_rem_d;
         logic [REM-1:0] a_rem_q;
         logic [REM-1:0] b_rem_q;

         if (k == 0) begin : g_src_in
            assign a_rem_d = A[WIDTH-1:CW];
            assign b_rem_d = w_beff[WIDTH-1:CW];
         end else begin : g_src_prev
            // Drop the chunk consumed here, pass the rest down the pipe.
            assign a_rem_d = g_stage[k-1].g_rem.a_rem_q[REM+CW-1:CW];
            assign b_rem_d = g_stage[k-1].g_rem.b_rem_q[REM+CW-1:CW];
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               a_rem_q <= '0;
               b_rem_q <= '0;
            end else if (w_adv && w_vin) begin
               a_rem_q <= a_rem_d;
               b_rem_q <= b_rem_d;
            end
         end
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
         end else if (w_adv) begin
            valid_q <= w_vin;
            if (w_vin) begin
               res_q   <= res_d;
               carry_q <= w_cout;
               sa_q    <= w_sa;
               sb_q    <= w_sb;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs come straight from the last stage register. Overflow is decoded
   // from registered sign bits only, so no input reaches an output
   // combinationally.
   // ------------------------------------------------------------------------
   assign out_valid = g_stage[STAGES-1].valid_q;
   assign C         = g_stage[STAGES-1].res_q;
   assign Cout      = g_stage[STAGES-1].carry_q;
   assign Overflow  = (g_stage[STAGES-1].sa_q == g_stage[STAGES-1].sb_q) &&
                      (C[MSB] != g_stage[STAGES-1].sa_q);

endmodule
`default_nettype wire

// File: tb/tb_pipe_add.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_add
// Purpose  : Self-checking bench for pipe_add. Three instances are built:
//            sel 0 = WIDTH 32 / STAGES 4, sel 1 = WIDTH 32 / STAGES 1,
//            sel 2 = WIDTH 64 / STAGES 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_add;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic        d0_iv, d0_ir, d0_sub, d0_cin, d0_ov, d0_or, d0_co, d0_of;
   logic [31:0] d0_a, d0_b, d0_c;
   logic        d1_iv, d1_ir, d1_sub, d1_cin, d1_ov, d1_or, d1_co, d1_of;
   logic [31:0] d1_a, d1_b, d1_c;
   logic        d2_iv, d2_ir, d2_sub, d2_cin, d2_ov, d2_or, d2_co, d2_of;
   logic [63:0] d2_a, d2_b, d2_c;

   pipe_add #(.WIDTH(32), .STAGES(4)) u_d0 (
      .clock(clock), .reset(reset), .in_valid(d0_iv), .in_ready(d0_ir),
      .A(d0_a), .B(d0_b), .Sub(d0_sub), .Cin(d0_cin), .out_valid(d0_ov),
      .out_ready(d0_or), .C(d0_c), .Cout(d0_co), .Overflow(d0_of));

   pipe_add #(.WIDTH(32), .STAGES(1)) u_d1 (
      .clock(clock), .reset(reset), .in_valid(d1_iv), .in_ready(d1_ir),
      .A(d1_a), .B(d1_b), .Sub(d1_sub), .Cin(d1_cin), .out_valid(d1_ov),
      .out_ready(d1_or), .C(d1_c), .Cout(d1_co), .Overflow(d1_of));

   pipe_add #(.WIDTH(64), .STAGES(8)) u_d2 (
      .clock(clock), .reset(reset), .in_valid(d2_iv), .in_ready(d2_ir),
      .A(d2_a), .B(d2_b), .Sub(d2_sub), .Cin(d2_cin), .out_valid(d2_ov),
      .out_ready(d2_or), .C(d2_c), .Cout(d2_co), .Overflow(d2_of));

   function automatic int wid(input int sel);
      return (sel == 2) ? 64 : 32;
   endfunction

   function automatic int stg(input int sel);
      case (sel)
         0:       return 4;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic string dname(input int sel);
      case (sel)
         0:       return "w32s4";
         1:       return "w32s1";
         default: return "w64s8";
      endcase
   endfunction

   function automatic logic [63:0] mask(input int sel);
      return (sel == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   // Whole-width reference: {Overflow, Cout, C}.
   function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic sub, input logic cin, input int w);
      logic [63:0] m;
      logic [63:0] am;
      logic [63:0] be;
      logic [64:0] s;
      logic        ovf;
      m   = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      am  = a & m;
      be  = (sub ? ~b : b) & m;
      s   = {1'b0, am} + {1'b0, be} + {64'd0, sub ^ cin};
      ovf = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
      return {ovf, s[w], s[63:0] & m};
   endfunction

   task automatic drive(input int sel, input logic iv, input logic [63:0] a,
                        input logic [63:0] b, input logic sub, input logic cin,
                        input logic ordy);
      case (sel)
         0: begin d0_iv = iv; d0_a = a[31:0]; d0_b = b[31:0]; d0_sub = sub; d0_cin = cin; d0_or = ordy; end
         1: begin d1_iv = iv; d1_a = a[31:0]; d1_b = b[31:0]; d1_sub = sub; d1_cin = cin; d1_or = ordy; end
         default: begin d2_iv = iv; d2_a = a; d2_b = b; d2_sub = sub; d2_cin = cin; d2_or = ordy; end
      endcase
   endtask

   task automatic sample(input int sel, output logic ov, output logic ir,
                         output logic [63:0] c, output logic co, output logic of);
      case (sel)
         0: begin ov = d0_ov; ir = d0_ir; c = {32'd0, d0_c}; co = d0_co; of = d0_of; end
         1: begin ov = d1_ov; ir = d1_ir; c = {32'd0, d1_c}; co = d1_co; of = d1_of; end
         default: begin ov = d2_ov; ir = d2_ir; c = d2_c; co = d2_co; of = d2_of; end
      endcase
   endtask

   task automatic test_reset();
      logic ov, ir, co, of;
      logic [63:0] c;
      repeat (2) @(negedge clock);
      for (int sel = 0; sel < 3; sel++) begin
         sample(sel, ov, ir, c, co, of);
         n_checks++;
         if (ov !== 1'b0) begin n_fail++; $display("FAIL %s reset_out_valid: got %b want 0", dname(sel), ov); end
         n_checks++;
         if (ir !== 1'b0) begin n_fail++; $display("FAIL %s reset_in_ready: got %b want 0", dname(sel), ir); end
         n_checks++;
         if (c !== 64'd0) begin n_fail++; $display("FAIL %s reset_C: got %h want 0", dname(sel), c); end
         n_checks++;
         if ({co, of} !== 2'b00) begin n_fail++; $display("FAIL %s reset_flags: got Cout=%b Ovf=%b want 0 0", dname(sel), co, of); end
      end
      reset = 1'b0;
      @(negedge clock);
      for (int sel = 0; sel < 3; sel++) begin
         sample(sel, ov, ir, c, co, of);
         n_checks++;
         if (ir !== 1'b1) begin n_fail++; $display("FAIL %s post_reset_in_ready: got %b want 1", dname(sel), ir); end
         n_checks++;
         if (ov !== 1'b0) begin n_fail++; $display("FAIL %s post_reset_out_valid: got %b want 0", dname(sel), ov); end
      end
   endtask

   // One operation into an empty pipe; checks latency, data and drain.
   task automatic single_op(input int sel, input string name, input logic [63:0] a,
                            input logic [63:0] b, input logic sub, input logic cin,
                            input logic [63:0] ec, input logic eco, input logic eof);
      logic ov, ir, co, of;
      logic [63:0] c;
      drive(sel, 1'b1, a, b, sub, cin, 1'b1);
      #1;
      sample(sel, ov, ir, c, co, of);
      n_checks++;
      if (ir !== 1'b1) begin n_fail++; $display("FAIL %s %s_in_ready: got %b want 1", dname(sel), name, ir); end
      @(negedge clock);
      // Operands go unknown once not valid; they must not leak into the result.
      drive(sel, 1'b0, 64'hx, 64'hx, 1'bx, 1'bx, 1'b1);
      for (int i = 1; i < stg(sel); i++) begin
         sample(sel, ov, ir, c, co, of);
         n_checks++;
         if (ov !== 1'b0) begin n_fail++; $display("FAIL %s %s_early_valid: got %b want 0 at edge %0d", dname(sel), name, ov, i); end
         @(negedge clock);
      end
      sample(sel, ov, ir, c, co, of);
      n_checks++;
      if (ov !== 1'b1) begin n_fail++; $display("FAIL %s %s_out_valid: got %b want 1", dname(sel), name, ov); end
      n_checks++;
      if (c !== ec) begin n_fail++; $display("FAIL %s %s_C: got %h want %h", dname(sel), name, c, ec); end
      n_checks++;
      if ({co, of} !== {eco, eof}) begin
         n_fail++; $display("FAIL %s %s_flags: got Cout=%b Ovf=%b want Cout=%b Ovf=%b", dname(sel), name, co, of, eco, eof);
      end
      @(negedge clock);
      sample(sel, ov, ir, c, co, of);
      n_checks++;
      if (ov !== 1'b0) begin n_fail++; $display("FAIL %s %s_drained: got %b want 0", dname(sel), name, ov); end
   endtask

   task automatic test_arith(input int sel);
      logic [63:0] m;
      logic [63:0] msb;
      m   = mask(sel);
      msb = 64'd1 << (wid(sel) - 1);
      single_op(sel, "carry_ripple", m,         64'd1,      1'b0, 1'b0, 64'd0,      1'b1, 1'b0);
      single_op(sel, "add_cin",      64'd1,     64'd2,      1'b0, 1'b1, 64'd4,      1'b0, 1'b0);
      single_op(sel, "add_ovf",      msb - 1,   64'd1,      1'b0, 1'b0, msb,        1'b0, 1'b1);
      single_op(sel, "sub_ovf",      msb,       64'd1,      1'b1, 1'b0, msb - 1,    1'b1, 1'b1);
      single_op(sel, "sub_neg",      64'd5,     64'd7,      1'b1, 1'b0, m - 64'd1,  1'b0, 1'b0);
      single_op(sel, "sub_borrow",   64'd10,    64'd3,      1'b1, 1'b1, 64'd6,      1'b1, 1'b0);
   endtask

   task automatic test_back_to_back(input int sel);
      logic [65:0] q[$];
      logic [65:0] exp_v;
      logic [63:0] a, b, c;
      logic sub, cin, iv, ordy, ov, ir, co, of;
      int acc, cons, cyc;
      acc = 0; cons = 0; cyc = 0;
      a   = {$urandom, $urandom} & mask(sel);
      b   = {$urandom, $urandom} & mask(sel);
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      while ((acc < 8 || cons < 8) && cyc < 200) begin
         iv   = (acc < 8);
         ordy = (cyc % 2 == 0);
         if (iv) drive(sel, 1'b1, a, b, sub, cin, ordy);
         else    drive(sel, 1'b0, 64'hx, 64'hx, 1'bx, 1'bx, ordy);
         #1;
         sample(sel, ov, ir, c, co, of);
         n_checks++;
         if (ir !== (~ov | ordy)) begin
            n_fail++; $display("FAIL %s b2b_in_ready: got %b want %b (out_valid=%b out_ready=%b)", dname(sel), ir, ~ov | ordy, ov, ordy);
         end
         if (ov === 1'b1) begin
            if (q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL %s b2b_extra_result: got C=%h want no result", dname(sel), c);
            end else begin
               exp_v = q[0];
               n_checks++;
               if ({of, co, c} !== exp_v) begin
                  n_fail++; $display("FAIL %s b2b_result%0d: got %h want %h", dname(sel), cons, {of, co, c}, exp_v);
               end
               if (ordy) begin
                  void'(q.pop_front());
                  cons++;
               end
            end
         end
         if (iv && ir === 1'b1) begin
            q.push_back(model(a, b, sub, cin, wid(sel)));
            acc++;
            a   = {$urandom, $urandom} & mask(sel);
            b   = {$urandom, $urandom} & mask(sel);
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
         end
         @(negedge clock);
         cyc++;
      end
      drive(sel, 1'b0, 64'hx, 64'hx, 1'bx, 1'bx, 1'b1);
      n_checks++;
      if (acc != 8 || cons != 8 || q.size() != 0) begin
         n_fail++; $display("FAIL %s b2b_count: got accepted=%0d consumed=%0d pending=%0d want 8 8 0", dname(sel), acc, cons, q.size());
      end
   endtask

   task automatic test_reset_midflight(input int sel);
      logic ov, ir, co, of;
      logic [63:0] c;
      int waited;
      for (int i = 0; i < 3; i++) begin
         drive(sel, 1'b1, 64'd100 + 64'(i), 64'(i), 1'b0, 1'b0, 1'b1);
         @(negedge clock);
      end
      // Hold the output so a result is sitting there when reset hits.
      drive(sel, 1'b0, 64'hx, 64'hx, 1'bx, 1'bx, 1'b0);
      waited = 0;
      sample(sel, ov, ir, c, co, of);
      while (ov !== 1'b1 && waited < 20) begin
         @(negedge clock);
         waited++;
         sample(sel, ov, ir, c, co, of);
      end
      n_checks++;
      if (ov !== 1'b1) begin n_fail++; $display("FAIL %s pre_reset_valid: got %b want 1 within 20 cycles", dname(sel), ov); end
      #2 reset = 1'b1;
      #1;
      sample(sel, ov, ir, c, co, of);
      n_checks++;
      if (ov !== 1'b0) begin n_fail++; $display("FAIL %s async_reset_valid: got %b want 0", dname(sel), ov); end
      n_checks++;
      if (c !== 64'd0) begin n_fail++; $display("FAIL %s async_reset_C: got %h want 0", dname(sel), c); end
      @(negedge clock);
      reset = 1'b0;
      drive(sel, 1'b0, 64'hx, 64'hx, 1'bx, 1'bx, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         sample(sel, ov, ir, c, co, of);
         n_checks++;
         if (ov !== 1'b0) begin n_fail++; $display("FAIL %s stale_after_reset: got out_valid=%b want 0 at cycle %0d", dname(sel), ov, i); end
      end
      single_op(sel, "post_reset", 64'h1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      for (int sel = 0; sel < 3; sel++) drive(sel, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      test_reset();
      for (int sel = 0; sel < 3; sel++) begin
         test_arith(sel);
         test_back_to_back(sel);
         test_reset_midflight(sel);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, want finish before 200us");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
